dispatch_queue: RTL and testbench
=================================

# dispatch_queue

Parametrised in-order dispatch buffer between rename and the three reservation stations (ALU, LSU, BRU). It accepts up to DISPATCH_WIDTH renamed instructions per cycle into a circular queue and classifies each by opcode. It releases them in program order, up to DISPATCH_WIDTH per cycle, only while the target station has a free-entry credit. Back-pressure reaches rename through `in_ready`; credits return from the stations on issue.

## Interface
- DISPATCH_WIDTH, 2: lanes per cycle on input and output (1..4)
- QUEUE_DEPTH, 8: queue entries; power of 2, >= 2*DISPATCH_WIDTH
- RS_DEPTH, 8: entries per reservation station; initial credit per class
- ROB_WIDTH, 4: ROB id width
- clk  in  1  clock, rising edge
- rst  in  1  asynchronous, active-high reset
- flush  in  1  pipeline flush
- in_valid  in  DISPATCH_WIDTH  lane valids; contiguous from lane 0, lane 0 oldest
- in_instr  in  DISPATCH_WIDTH x instruction_t  renamed instructions
- in_rob_id  in  DISPATCH_WIDTH x ROB_WIDTH  ROB ids
- in_ready  out  1  queue can accept a full group this cycle
- out_valid  out  DISPATCH_WIDTH  lane dispatched this cycle
- out_instr  out  DISPATCH_WIDTH x instruction_t  dispatched instructions
- out_rob_id  out  DISPATCH_WIDTH x ROB_WIDTH  ROB ids
- out_class  out  DISPATCH_WIDTH x 2  0=ALU, 1=LSU, 2=BRU
- rs_release  in  3  per-class pulse: that station freed one entry this cycle
- stall_cycles  out  3 x 32  per-class head-blocked cycle counters (see Configuration)

## Operation
- Classification happens at enqueue:
  - ALU: OP_IMM, OP, LUI, AUIPC, SYSTEM, and any unlisted opcode.
  - LSU: LOAD, STORE.
  - BRU: BRANCH, JAL, JALR.
- Enqueue: when in_ready && !flush, the lanes with in_valid set are written at tail, tail+1, …, in lane order. Tail and count advance by popcount(in_valid).
- in_ready = !flush && (QUEUE_DEPTH - count) >= DISPATCH_WIDTH. The flag is all-or-nothing; partial groups are never accepted.
- Dispatch: output lane k presents entry head+k. It is valid iff all of the following hold:
  - count > k
  - lanes 0..k-1 are valid
  - credit[class] minus the number of earlier valid lanes of the same class this cycle is > 0
  - flush is low
- The first blocked lane blocks all younger lanes, which preserves strict program order.
- Head advances and count drops by popcount(out_valid). Pointers wrap modulo QUEUE_DEPTH. count is $clog2(QUEUE_DEPTH)+1 bits.
- Credits: credit[c] is $clog2(RS_DEPTH)+1 bits, reset to RS_DEPTH. Each cycle, credit[c] += rs_release[c] - (dispatched lanes of class c). Credit never exceeds RS_DEPTH. A release arriving at RS_DEPTH is a protocol error; the counter saturates and an assertion fires in simulation.
- Flush is synchronous. On the next edge head = tail = count = 0 and every credit returns to RS_DEPTH, because the stations flush too. rs_release in a flush cycle is ignored.

## Timing
- Reset (async): count=0, head=tail=0, credits=RS_DEPTH, out_valid=0, in_ready=1, stall counters=0.
- Outputs are driven from queue registers and credit state. An instruction enqueued at edge t can dispatch at the earliest in cycle t+1 (1-cycle latency). There is no bypass from input to output.
- Simultaneous enqueue and dispatch in one cycle is allowed: count_next = count + enq - deq.
- A release at edge t can be consumed by a dispatch in cycle t+1.
- Queue full: in_ready=0 while dispatch continues. Queue empty: out_valid=0.
- Reset asserted mid-operation drops all entries immediately.

## Configuration
- DISPATCH_STATS_EN defined: stall_cycles[c] increments, saturating at 2^32-1, in each cycle where count>0, !flush, and the first undispatched entry in program order is class c blocked on zero effective credit. The counters clear only on rst.
- DISPATCH_STATS_EN undefined: no counter logic is built and stall_cycles reads constant 0.

## Test plan
- Reset, then 2 ALU instructions (rob 0,1) in one cycle -> next cycle out_valid=2'b11, out_class 0,0; in_ready stays 1.
- RS_DEPTH=2, enqueue 3 LSU instructions with no releases -> 2 dispatch, third held, head LSU stall counter increments each cycle. A single rs_release[1] pulse -> third dispatches the following cycle.
- Group {LSU, ALU} with LSU credit 0 -> out_valid=2'b00. The ALU is not dispatched past the blocked LSU.
- Fill 8 entries with all credits 0 -> in_ready=0 and count=8. Restore credits -> drain in order with rob ids 0..7, tail wrapping correctly on refill.
- Flush with 5 entries queued and credit ALU=3 -> same cycle out_valid=0 and in_ready=0. Next cycle count=0, all credits=8, in_ready=1.
- Assert rst asynchronously between edges with the queue half full -> out_valid drops to 0 and in_ready to 1 without waiting for a clock edge.

Source files
------------

// File: rtl/dispatch_queue.sv
// dispatch_queue: in-order rename->RS dispatch buffer with per-class credits.
// Define DISPATCH_STATS_EN to build the per-class head-stall counters.
module dispatch_queue #(
    parameter int DISPATCH_WIDTH = 2,
    parameter int QUEUE_DEPTH    = 8,
    parameter int RS_DEPTH       = 8,
    parameter int ROB_WIDTH      = 4
) (
    input  logic                                     clk,
    input  logic                                     rst,
    input  logic                                     flush,
    input  logic [DISPATCH_WIDTH-1:0]                in_valid,
    input  logic [DISPATCH_WIDTH-1:0][31:0]          in_instr,
    input  logic [DISPATCH_WIDTH-1:0][ROB_WIDTH-1:0] in_rob_id,
    output logic                                     in_ready,
    output logic [DISPATCH_WIDTH-1:0]                out_valid,
    output logic [DISPATCH_WIDTH-1:0][31:0]          out_instr,
    output logic [DISPATCH_WIDTH-1:0][ROB_WIDTH-1:0] out_rob_id,
    output logic [DISPATCH_WIDTH-1:0][1:0]           out_class,
    input  logic [2:0]                               rs_release,
    output logic [2:0][31:0]                         stall_cycles
);
    localparam int PW = $clog2(QUEUE_DEPTH);
    localparam int CW = PW + 1;
    localparam int KW = $clog2(RS_DEPTH) + 1;
    localparam int SW = KW + 1;

    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;

    localparam logic [1:0] CLS_ALU = 2'd0;
    localparam logic [1:0] CLS_LSU = 2'd1;
    localparam logic [1:0] CLS_BRU = 2'd2;

    logic [31:0]          instr_q [QUEUE_DEPTH];
    logic [ROB_WIDTH-1:0] rob_q   [QUEUE_DEPTH];
    logic [1:0]           cls_q   [QUEUE_DEPTH];

    logic [PW-1:0]                     head;
    logic [PW-1:0]                     tail;
    logic [CW-1:0]                     count;
    logic [CW-1:0]                     enq;
    logic [CW-1:0]                     deq;
    logic [2:0][KW-1:0]                credit;
    logic [2:0][KW-1:0]                used;
    logic [2:0][KW-1:0]                credit_next;
    logic [2:0][SW-1:0]                credit_sum;
    logic [2:0]                        over;
    logic [DISPATCH_WIDTH-1:0][PW-1:0] wr_idx;
    logic [DISPATCH_WIDTH-1:0][PW-1:0] rd_idx;
    logic                              blocked;

    function automatic logic [1:0] classify(input logic [6:0] op);
        logic [1:0] c;
        unique case (1'b1)
            op == OPC_LOAD,
            op == OPC_STORE:  c = CLS_LSU;
            op == OPC_BRANCH,
            op == OPC_JAL,
            op == OPC_JALR:   c = CLS_BRU;
            default:          c = CLS_ALU;
        endcase
        return c;
    endfunction

    assign in_ready = !flush &&
        ((CW'(QUEUE_DEPTH) - count) >= CW'(DISPATCH_WIDTH));

    // Valid lanes pack densely from tail in lane order.
    always_comb begin
        enq = '0;
        for (int k = 0; k < DISPATCH_WIDTH; k++) begin
            wr_idx[k] = tail + enq[PW-1:0];
            if (in_valid[k]) begin
                enq = enq + CW'(1);
            end
        end
    end

    // The first lane that cannot go blocks every younger lane.
    always_comb begin
        out_valid = '0;
        used      = '0;
        deq       = '0;
        blocked   = flush;
        for (int k = 0; k < DISPATCH_WIDTH; k++) begin
            rd_idx[k]     = head + PW'(k);
            out_instr[k]  = instr_q[rd_idx[k]];
            out_rob_id[k] = rob_q[rd_idx[k]];
            out_class[k]  = cls_q[rd_idx[k]];
            if (!blocked && count > CW'(k) &&
                credit[out_class[k]] != used[out_class[k]]) begin
                out_valid[k]         = 1'b1;
                used[out_class[k]]   = used[out_class[k]] + KW'(1);
                deq                  = deq + CW'(1);
            end else begin
                blocked = 1'b1;
            end
        end
    end

    always_comb begin
        for (int c = 0; c < 3; c++) begin
            credit_sum[c] = {1'b0, credit[c]} + SW'(rs_release[c])
                          - {1'b0, used[c]};
            over[c] = credit_sum[c] > SW'(RS_DEPTH);
            credit_next[c] = over[c] ? KW'(RS_DEPTH)
                                     : credit_sum[c][KW-1:0];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
            for (int c = 0; c < 3; c++) begin
                credit[c] <= KW'(RS_DEPTH);
            end
        end else if (flush) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
            for (int c = 0; c < 3; c++) begin
                credit[c] <= KW'(RS_DEPTH);
            end
        end else begin
            head  <= head + deq[PW-1:0];
            if (in_ready) begin
                tail <= tail + enq[PW-1:0];
            end
            count  <= count + (in_ready ? enq : '0) - deq;
            credit <= credit_next;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst && in_ready) begin
            for (int k = 0; k < DISPATCH_WIDTH; k++) begin
                if (in_valid[k]) begin
                    instr_q[wr_idx[k]] <= in_instr[k];
                    rob_q[wr_idx[k]]   <= in_rob_id[k];
                    cls_q[wr_idx[k]]   <= classify(in_instr[k][6:0]);
                end
            end
        end
    end

    // A station returning more entries than it owns is a protocol error.
    always_ff @(posedge clk) begin
        if (!rst && !flush) begin
            for (int c = 0; c < 3; c++) begin
                assert (!over[c])
                    else $error("dispatch_queue: credit overrun class %0d", c);
            end
        end
    end

`ifdef DISPATCH_STATS_EN
    logic [2:0]       stall_hit;
    logic [2:0][31:0] stall_q;
    logic             found;

    always_comb begin
        stall_hit = '0;
        found     = 1'b0;
        for (int k = 0; k < DISPATCH_WIDTH; k++) begin
            if (!found && !out_valid[k]) begin
                found = 1'b1;
                if (!flush && count > CW'(k)) begin
                    stall_hit[out_class[k]] = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stall_q <= '0;
        end else begin
            for (int c = 0; c < 3; c++) begin
                if (stall_hit[c] && stall_q[c] != '1) begin
                    stall_q[c] <= stall_q[c] + 32'd1;
                end
            end
        end
    end

    assign stall_cycles = stall_q;
`else
    assign stall_cycles = '0;
`endif

endmodule

// File: tb/tb_dispatch_queue.sv
// tb_dispatch_queue: directed + randomized stimulus for dispatch_queue,
// checked against a queue-based reference model of the dispatch rules.
module tb_dispatch_queue;
    localparam int DW  = 2;
    localparam int QD  = 8;
    localparam int RS  = 8;
    localparam int RW  = 4;

    typedef struct packed {
        logic [31:0]   instr;
        logic [RW-1:0] rob;
        logic [1:0]    cls;
    } ent_t;

    logic                      clk = 1'b0;
    logic                      rst;
    logic                      flush;
    logic [DW-1:0]             in_valid;
    logic [DW-1:0][31:0]       in_instr;
    logic [DW-1:0][RW-1:0]     in_rob_id;
    logic                      in_ready;
    logic [DW-1:0]             out_valid;
    logic [DW-1:0][31:0]       out_instr;
    logic [DW-1:0][RW-1:0]     out_rob_id;
    logic [DW-1:0][1:0]        out_class;
    logic [2:0]                rs_release;
    logic [2:0][31:0]          stall_cycles;

    int     nassert = 0;
    int     nfail   = 0;
    ent_t   mq[$];
    int     cred[3];
    longint stall[3];
    int     rob_ctr = 0;

    dispatch_queue #(
        .DISPATCH_WIDTH(DW),
        .QUEUE_DEPTH(QD),
        .RS_DEPTH(RS),
        .ROB_WIDTH(RW)
    ) dut (
        .clk(clk),
        .rst(rst),
        .flush(flush),
        .in_valid(in_valid),
        .in_instr(in_instr),
        .in_rob_id(in_rob_id),
        .in_ready(in_ready),
        .out_valid(out_valid),
        .out_instr(out_instr),
        .out_rob_id(out_rob_id),
        .out_class(out_class),
        .rs_release(rs_release),
        .stall_cycles(stall_cycles)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs,
                         input logic [63:0] exp);
        nassert++;
        assert (obs === exp) else begin
            nfail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Class by RISC-V major opcode.
    function automatic logic [1:0] ref_class(input logic [6:0] op);
        case (op)
            7'h03, 7'h23:        return 2'd1;
            7'h63, 7'h6f, 7'h67: return 2'd2;
            default:             return 2'd0;
        endcase
    endfunction

    // cls < 0 picks any class, including an unlisted opcode.
    function automatic logic [31:0] mk_instr(input int cls);
        logic [31:0] hi;
        logic [6:0]  op;
        int          r;
        int          c;
        hi = $urandom();
        r  = $urandom_range(0, 5);
        c  = (cls < 0) ? $urandom_range(0, 2) : cls;
        case (c)
            1:       op = r[0] ? 7'h03 : 7'h23;
            2:       op = (r % 3 == 0) ? 7'h63 :
                          (r % 3 == 1) ? 7'h6f : 7'h67;
            default: case (r)
                         0:       op = 7'h13;
                         1:       op = 7'h33;
                         2:       op = 7'h37;
                         3:       op = 7'h17;
                         4:       op = 7'h73;
                         default: op = 7'h0b;
                     endcase
        endcase
        return {hi[31:7], op};
    endfunction

    function automatic longint exp_stall(input int c);
`ifdef DISPATCH_STATS_EN
        return stall[c];
`else
        return 0;
`endif
    endfunction

    task automatic model_reset();
        mq.delete();
        for (int c = 0; c < 3; c++) begin
            cred[c]  = RS;
            stall[c] = 0;
        end
        rob_ctr = 0;
    endtask

    // One clock cycle: drive, predict, check at negedge, advance model.
    task automatic step(input bit fl, input int nv, input int c0,
                        input int c1, input bit [2:0] rmask,
                        input int pct);
        logic [DW-1:0] ev;
        logic [31:0]   ins[DW];
        int            used[3];
        bit            blk;
        bit            er;
        int            nd;
        int            cl;
        flush      = fl;
        in_valid   = '0;
        rs_release = '0;
        for (int k = 0; k < DW; k++) begin
            ins[k]       = mk_instr(k == 0 ? c0 : c1);
            in_instr[k]  = ins[k];
            in_rob_id[k] = RW'(rob_ctr + k);
            if (k < nv) in_valid[k] = 1'b1;
        end
        for (int c = 0; c < 3; c++) begin
            used[c] = 0;
            if (rmask[c] && cred[c] < RS &&
                $urandom_range(0, 99) < pct) rs_release[c] = 1'b1;
        end
        er  = !fl && (QD - mq.size()) >= DW;
        ev  = '0;
        blk = fl;
        nd  = 0;
        for (int k = 0; k < DW; k++) begin
            if (!blk && k < mq.size() &&
                cred[mq[k].cls] - used[mq[k].cls] > 0) begin
                ev[k] = 1'b1;
                used[mq[k].cls]++;
                nd++;
            end else begin
                blk = 1'b1;
            end
        end
        @(negedge clk);
        check("in_ready", 64'(in_ready), 64'(er));
        check("out_valid", 64'(out_valid), 64'(ev));
        for (int k = 0; k < DW; k++) begin
            if (ev[k]) begin
                check($sformatf("out_instr[%0d]", k),
                      64'(out_instr[k]), 64'(mq[k].instr));
                check($sformatf("out_rob_id[%0d]", k),
                      64'(out_rob_id[k]), 64'(mq[k].rob));
                check($sformatf("out_class[%0d]", k),
                      64'(out_class[k]), 64'(mq[k].cls));
            end
        end
        for (int c = 0; c < 3; c++) begin
            check($sformatf("stall_cycles[%0d]", c),
                  64'(stall_cycles[c]), 64'(exp_stall(c)));
        end
        @(posedge clk);
        if (fl) begin
            mq.delete();
            for (int c = 0; c < 3; c++) cred[c] = RS;
        end else begin
            if (nd < DW && nd < mq.size()) stall[mq[nd].cls]++;
            repeat (nd) void'(mq.pop_front());
            for (int c = 0; c < 3; c++) begin
                cred[c] = cred[c] + int'(rs_release[c]) - used[c];
            end
            if (er) begin
                for (int k = 0; k < nv; k++) begin
                    cl = ref_class(ins[k][6:0]);
                    mq.push_back('{ins[k], RW'(rob_ctr + k), 2'(cl)});
                end
                rob_ctr += nv;
            end
        end
        #1;
    endtask

    task automatic async_reset();
        flush      = 1'b0;
        in_valid   = '0;
        rs_release = '0;
        #2 rst = 1'b1;
        #1;
        check("rst_out_valid", 64'(out_valid), 64'(0));
        check("rst_in_ready", 64'(in_ready), 64'(1));
        for (int c = 0; c < 3; c++) begin
            check($sformatf("rst_stall[%0d]", c),
                  64'(stall_cycles[c]), 64'(0));
        end
        model_reset();
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
    endtask

    initial begin
        int pcts[6];
        pcts       = '{80, 0, 30, 100, 10, 60};
        rst        = 1'b1;
        flush      = 1'b0;
        in_valid   = '0;
        in_instr   = '0;
        in_rob_id  = '0;
        rs_release = '0;
        model_reset();
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        check("reset_in_ready", 64'(in_ready), 64'(1));
        check("reset_out_valid", 64'(out_valid), 64'(0));
        for (int c = 0; c < 3; c++) begin
            check($sformatf("reset_stall[%0d]", c),
                  64'(stall_cycles[c]), 64'(0));
        end
        @(posedge clk);
        #1;

        // Two ALU ops, dispatched together one cycle later.
        step(0, 2, 0, 0, 3'b000, 0);
        step(0, 0, 0, 0, 3'b000, 0);

        // Exhaust LSU credit, hold the excess, then one release.
        repeat (5) step(0, 2, 1, 1, 3'b000, 0);
        repeat (3) step(0, 0, 0, 0, 3'b000, 0);
        step(0, 0, 0, 0, 3'b010, 100);
        repeat (2) step(0, 0, 0, 0, 3'b000, 0);

        // ALU stuck behind a credit-blocked LSU, then fill to full.
        step(0, 2, 1, 0, 3'b000, 0);
        repeat (2) step(0, 0, 0, 0, 3'b000, 0);
        repeat (5) step(0, 2, -1, -1, 3'b000, 0);

        // Restore credit and drain in order.
        repeat (12) step(0, 0, 0, 0, 3'b111, 100);

        // Flush with a blocked queue and live input group.
        repeat (6) step(0, 2, 1, 0, 3'b000, 0);
        step(1, 2, 0, 0, 3'b111, 100);
        step(0, 2, 0, 2, 3'b000, 0);
        step(0, 0, 0, 0, 3'b000, 0);

        // Random traffic with varying release pressure.
        for (int b = 0; b < 6; b++) begin
            for (int i = 0; i < 50; i++) begin
                step($urandom_range(0, 99) < 2, $urandom_range(0, 2),
                     -1, -1, 3'b111, pcts[b]);
            end
        end

        // Asynchronous reset with entries pending.
        repeat (4) step(0, 2, -1, -1, 3'b000, 0);
        async_reset();
        repeat (40) step(0, $urandom_range(0, 2), -1, -1,
                         3'b111, 50);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 nassert, nfail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not reach the end");
        $fatal(1, "timeout");
    end
endmodule
